// File: rtl/eyeriss_if_pkg.sv
// eyeriss_if_pkg: shared types and default widths for the interface-unit FIFO path.
package eyeriss_if_pkg;
  typedef enum logic [1:0] {IDLE, RUN, FINISH} drain_state_t;
  localparam int FIFO_WIDTH_D = 64;
  localparam int ADDR_WIDTH_D = 20;
endpackage

// File: rtl/drain_out_stage.sv
// drain_out_stage: single-entry valid/ready output register with load, accept and flush.
module drain_out_stage
  import eyeriss_if_pkg::*;
#(
  parameter int DW = FIFO_WIDTH_D,
  parameter int AW = ADDR_WIDTH_D
) (
  input  logic          rclk,
  input  logic          rreset,
  input  logic          load_i,
  input  logic          accept_i,
  input  logic          flush_i,
  input  logic [DW-1:0] data_i,
  input  logic [AW-1:0] addr_i,
  input  logic          last_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output logic [AW-1:0] addr_o,
  output logic          last_o
);
  logic          valid_q, valid_d, last_q, last_d;
  logic [DW-1:0] data_q, data_d;
  logic [AW-1:0] addr_q, addr_d;
  always_comb begin
    valid_d = flush_i ? 1'b0 : load_i ? 1'b1 : accept_i ? 1'b0 : valid_q;
    data_d  = load_i ? data_i : data_q;
    addr_d  = load_i ? addr_i : addr_q;
    last_d  = load_i ? last_i : last_q;
  end
  always_ff @(posedge rclk or posedge rreset)
    if (rreset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      addr_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      last_q  <= last_d;
    end
  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign addr_o  = addr_q;
  assign last_o  = last_q;
endmodule

// File: rtl/fifo_dram_drain.sv
// fifo_dram_drain: pops the back-path async FIFO and streams words to the DRAM write port in bursts.
// Define DRAIN_PERF_EN to add the saturating stall_cnt port.
module fifo_dram_drain
  import eyeriss_if_pkg::*;
#(
  parameter int FIFO_WIDTH = FIFO_WIDTH_D,
  parameter int ADDR_WIDTH = ADDR_WIDTH_D,
  parameter int CNT_WIDTH  = 16,
  parameter int BURST_LEN  = 8
) (
  input  logic                  rclk,
  input  logic                  rreset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [ADDR_WIDTH-1:0] base_address,
  input  logic [CNT_WIDTH-1:0]  total_words,
  input  logic                  rempty,
  input  logic [FIFO_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  dram_ready,
  output logic                  dram_valid,
  output logic [FIFO_WIDTH-1:0] dram_wdata,
  output logic [ADDR_WIDTH-1:0] dram_addr,
  output logic                  dram_last,
  output logic                  busy,
  output logic                  done
`ifdef DRAIN_PERF_EN
  ,output logic [31:0]          stall_cnt
`endif
);
  localparam int BW = BURST_LEN > 1 ? $clog2(BURST_LEN) : 1;
  localparam logic [BW-1:0] BEAT_MAX = BW'(BURST_LEN - 1);
  drain_state_t          state_q;
  logic [CNT_WIDTH-1:0]  to_pop_q, to_send_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [BW-1:0]         beat_q;
  logic                  accept, last_w, in_run;
  assign in_run = state_q == RUN;
  assign accept = dram_valid & dram_ready;
  assign last_w = (beat_q == BEAT_MAX) | (to_pop_q == CNT_WIDTH'(1));
  assign rinc   = in_run & ~rempty & (to_pop_q != '0) & (~dram_valid | dram_ready) & ~abort;
  assign busy   = in_run;
  assign done   = state_q == FINISH;
  always_ff @(posedge rclk or posedge rreset)
    if (rreset) begin
      state_q   <= IDLE;
      to_pop_q  <= '0;
      to_send_q <= '0;
      addr_q    <= '0;
      beat_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q   <= (total_words != '0) ? RUN : FINISH;
          to_pop_q  <= total_words;
          to_send_q <= total_words;
          addr_q    <= base_address;
          beat_q    <= '0;
        end
        RUN: if (abort) state_q <= IDLE;
        else begin
          if (rinc) begin
            to_pop_q <= to_pop_q - CNT_WIDTH'(1);
            addr_q   <= addr_q + ADDR_WIDTH'(1);
            beat_q   <= last_w ? '0 : beat_q + BW'(1);
          end
          if (accept) begin
            to_send_q <= to_send_q - CNT_WIDTH'(1);
            if (to_send_q == CNT_WIDTH'(1)) state_q <= FINISH;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  drain_out_stage #(.DW(FIFO_WIDTH), .AW(ADDR_WIDTH)) u_out (
    .rclk    (rclk),
    .rreset  (rreset),
    .load_i  (rinc),
    .accept_i(accept),
    .flush_i (in_run & abort),
    .data_i  (rdata),
    .addr_i  (addr_q),
    .last_i  (last_w),
    .valid_o (dram_valid),
    .data_o  (dram_wdata),
    .addr_o  (dram_addr),
    .last_o  (dram_last)
  );
`ifdef DRAIN_PERF_EN
  logic [31:0] stall_q;
  always_ff @(posedge rclk or posedge rreset)
    if (rreset) stall_q <= '0;
    else if (start && state_q == IDLE) stall_q <= '0;
    else if (dram_valid && !dram_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
  assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_fifo_dram_drain.sv
// tb_fifo_dram_drain: scoreboard bench for fifo_dram_drain with a queue-modelled FIFO.
module tb_fifo_dram_drain;
  logic        rclk = 1'b0;
  logic        rreset, start, abort, rempty, rinc, dram_ready, dram_valid, dram_last, busy, done;
  logic [19:0] base_address, dram_addr;
  logic [15:0] total_words;
  logic [63:0] rdata, dram_wdata;
`ifdef DRAIN_PERF_EN
  logic [31:0] stall_cnt;
`endif
  fifo_dram_drain dut (
    .rclk(rclk), .rreset(rreset), .start(start), .abort(abort),
    .base_address(base_address), .total_words(total_words),
    .rempty(rempty), .rdata(rdata), .rinc(rinc),
    .dram_ready(dram_ready), .dram_valid(dram_valid), .dram_wdata(dram_wdata),
    .dram_addr(dram_addr), .dram_last(dram_last), .busy(busy), .done(done)
`ifdef DRAIN_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );
  always #5 rclk = ~rclk;
  typedef struct packed {logic [63:0] d; logic [19:0] a; logic l;} exp_t;
  exp_t        sb[$];
  logic [63:0] fifo[$];
  int          checks = 0, failures = 0, tc = 0, seq = 0;
  int          acc_cnt, rinc_cnt, first_rinc_t, last_rinc_t, last_acc_t, done_t, done_cnt, start_t, k, total_m;
  logic [19:0] base_m, pa;
  logic [63:0] pd;
  logic        pl, busy_at_done, hold_prev = 1'b0;
  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (t=%0d)", tag, got, exp, tc);
    end
  endtask
  task automatic fill(int n);
    for (int i = 0; i < n; i++) begin
      fifo.push_back({$urandom, 32'(seq)});
      seq++;
    end
  endtask
  task automatic tick();
    exp_t e;
    rempty = fifo.size() == 0;
    rdata  = rempty ? '0 : fifo[0];
    #1;
    if (hold_prev) begin
      check("hold_data", dram_wdata, pd);
      check("hold_addr", dram_addr, pa);
      check("hold_last", dram_last, pl);
      check("hold_valid", dram_valid, 1);
    end
    if (dram_valid && dram_ready) begin
      if (sb.size() == 0) check("sb_underflow", sb.size(), 1);
      else begin
        e = sb.pop_front();
        check("wdata", dram_wdata, e.d);
        check("addr", dram_addr, e.a);
        check("last", dram_last, e.l);
      end
      acc_cnt++;
      last_acc_t = tc;
    end
    if (rinc) begin
      e.d = fifo.pop_front();
      e.a = base_m + 20'(k);
      e.l = (k % 8 == 7) || (k == total_m - 1);
      sb.push_back(e);
      k++;
      rinc_cnt++;
      if (first_rinc_t < 0) first_rinc_t = tc;
      last_rinc_t = tc;
    end
    if (done) begin
      done_cnt++;
      done_t = tc;
      busy_at_done = busy;
    end
    hold_prev = dram_valid & ~dram_ready;
    pd = dram_wdata;
    pa = dram_addr;
    pl = dram_last;
    tc++;
    @(negedge rclk);
  endtask
  task automatic start_xfer(logic [19:0] b, int n);
    base_address = b;
    total_words  = 16'(n);
    base_m = b; total_m = n; k = 0;
    acc_cnt = 0; rinc_cnt = 0; first_rinc_t = -1; done_cnt = 0; done_t = -1;
    start_t = tc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic wait_done(int lim);
    for (int i = 0; i < lim && done_cnt == 0; i++) tick();
    check("done_seen", done_cnt, 1);
  endtask
  task automatic wait_acc(int n, int lim);
    for (int i = 0; i < lim && acc_cnt < n; i++) tick();
    check("acc_reached", acc_cnt, n);
  endtask
  initial begin
    rreset = 1'b1; start = 1'b0; abort = 1'b0; dram_ready = 1'b1;
    base_address = '0; total_words = '0; rempty = 1'b1; rdata = '0;
    repeat (2) @(negedge rclk);
    check("rst_rinc", rinc, 0);
    check("rst_valid", dram_valid, 0);
    check("rst_wdata", dram_wdata, 0);
    check("rst_addr", dram_addr, 0);
    check("rst_last", dram_last, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
`ifdef DRAIN_PERF_EN
    check("rst_stall", stall_cnt, 0);
`endif
    rreset = 1'b0;
    tick();
    // streaming transfer at full rate
    fill(10);
    start_xfer(20'h100, 10);
    wait_done(40);
    tick();
    check("t1_rinc_cnt", rinc_cnt, 10);
    check("t1_rinc_span", last_rinc_t - first_rinc_t, 9);
    check("t1_first_rinc", first_rinc_t, start_t + 1);
    check("t1_done_lat", done_t, last_acc_t + 1);
    check("t1_busy_at_done", busy_at_done, 0);
    check("t1_done_once", done_cnt, 1);
    check("t1_sb_empty", sb.size(), 0);
    // DRAM back-pressure mid-burst
    fill(8);
    start_xfer(20'h200, 8);
    wait_acc(3, 20);
    dram_ready = 1'b0;
    repeat (3) begin
      tick();
      check("t2_stall_rinc", rinc, 0);
      check("t2_stall_valid", dram_valid, 1);
    end
`ifdef DRAIN_PERF_EN
    check("t2_stall_cnt", stall_cnt, 3);
`endif
    dram_ready = 1'b1;
    wait_done(30);
    check("t2_acc", acc_cnt, 8);
    check("t2_sb_empty", sb.size(), 0);
    // FIFO runs dry then refills
    fill(4);
    start_xfer(20'h300, 6);
    wait_acc(4, 20);
    tick();
    check("t3_valid_drop", dram_valid, 0);
    check("t3_busy_hold", busy, 1);
    repeat (3) tick();
    check("t3_still_busy", busy, 1);
    fill(2);
    wait_done(20);
    check("t3_acc", acc_cnt, 6);
    check("t3_sb_empty", sb.size(), 0);
    // address wrap inside a burst
    fill(4);
    start_xfer(20'hFFFFE, 4);
    wait_done(20);
    check("t4_acc", acc_cnt, 4);
    check("t4_sb_empty", sb.size(), 0);
    // zero-length transfer
    start_xfer(20'h0, 0);
    repeat (3) tick();
    check("t5_rinc", rinc_cnt, 0);
    check("t5_done_once", done_cnt, 1);
    check("t5_done_lat_ok", (done_t - start_t >= 1) && (done_t - start_t <= 2), 1);
    // abort together with the third acceptance
    fill(8);
    dram_ready = 1'b0;
    start_xfer(20'h400, 8);
    for (int i = 0; i < 10 && !dram_valid; i++) tick();
    check("t6_first_valid", dram_valid, 1);
    for (int i = 0; i < 3; i++) begin
      dram_ready = 1'b1;
      abort = (i == 2);
      tick();
    end
    dram_ready = 1'b0;
    abort = 1'b0;
    check("t6_valid", dram_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    check("t6_acc", acc_cnt, 3);
    check("t6_fifo_left", fifo.size(), 5);
    tick();
    check("t6_no_done", done_cnt, 0);
    sb.delete();
    // asynchronous reset in the middle of a transfer
    dram_ready = 1'b1;
    start_xfer(20'h500, 5);
    tick();
    tick();
    check("t7_pre_valid", dram_valid, 1);
    #2 rreset = 1'b1;
    #1;
    check("t7_rinc", rinc, 0);
    check("t7_valid", dram_valid, 0);
    check("t7_wdata", dram_wdata, 0);
    check("t7_addr", dram_addr, 0);
    check("t7_last", dram_last, 0);
    check("t7_busy", busy, 0);
    check("t7_done", done, 0);
`ifdef DRAIN_PERF_EN
    check("t7_stall", stall_cnt, 0);
`endif
    @(negedge rclk);
    rreset = 1'b0;
    sb.delete();
    hold_prev = 1'b0;
    tick();
    check("t7_idle", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
